kgp_reg_file: RTL and testbench

Parametrised successor to the single-write-port register file of the KGPRISC datapath. It provides NUM_RD combinational read ports and two prioritised write ports (ALU writeback, memory writeback), with register 0 hardwired to zero. It adds optional write-to-read bypass and a per-register busy scoreboard that the decode stage uses for load-use and multi-cycle hazard detection. It sits between decode (reads, claims) and the writeback stage (writes, releases).

---
 rtl/kgp_rf_pkg.sv | 15 +
 rtl/kgp_rf_scoreboard.sv | 58 +++++
 rtl/kgp_reg_file.sv | 124 ++++++++++++
 tb/tb_kgp_reg_file.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_rf_pkg.sv
// Shared constants and helpers for the KGPRISC register file and its scoreboard.
package kgp_rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Address of the hardwired-zero register.
    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    // Bit offset of port 'port' inside a flat bus of 'width'-bit lanes.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/kgp_rf_scoreboard.sv
// Per-register busy scoreboard: decode claims a register when it issues a
// producer with a pending result, writeback releases it when the result lands.
// A claim beats a release on the same register in the same cycle because the
// claim belongs to a younger producer.
module kgp_rf_scoreboard
    import kgp_rf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  claim_en,
    input  logic [ADDR_W-1:0]     claim_addr,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    output logic [2**ADDR_W-1:0]  busy,
    output logic                  busy_any
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_r;
    logic [DEPTH-1:0] busy_nxt_s;
    logic             busy_any_r;

    // Next busy state: claim sets, write clears, register 0 is never busy.
    always_comb begin
        busy_nxt_s    = busy_r;
        busy_nxt_s[0] = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (claim_en && (claim_addr == ADDR_W'(i))) begin
                busy_nxt_s[i] = 1'b1;
            end else if ((wa_en && (wa_addr == ADDR_W'(i))) ||
                         (wb_en && (wb_addr == ADDR_W'(i)))) begin
                busy_nxt_s[i] = 1'b0;
            end else begin
                busy_nxt_s[i] = busy_r[i];
            end
        end
    end

    // Busy bits and their OR, both held as registered state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r     <= {DEPTH{1'b0}};
            busy_any_r <= 1'b0;
        end else begin
            busy_r     <= busy_nxt_s;
            busy_any_r <= |busy_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign busy_any = busy_any_r;

endmodule

// File: rtl/kgp_reg_file.sv
// KGPRISC register file: NUM_RD combinational read ports, two prioritised
// write ports (B = memory writeback wins over A = ALU writeback), register 0
// hardwired to zero, optional same-cycle write-to-read bypass and a busy
// scoreboard for hazard detection in decode.
module kgp_reg_file
    import kgp_rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     busy_any
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_vec_s;
    logic              wa_act_s;
    logic              wb_act_s;
    logic              wa_store_s;
    logic              claim_act_s;

    // Writes, claims and bypass are all suppressed while reset is high, and
    // writes to register 0 are discarded before they reach anything.
    assign wa_act_s    = wa_en && !reset && (wa_addr != ZERO_ADDR);
    assign wb_act_s    = wb_en && !reset && (wb_addr != ZERO_ADDR);
    assign claim_act_s = claim_en && !reset && (claim_addr != ZERO_ADDR);
    // Port A loses to port B on a shared address.
    assign wa_store_s  = wa_act_s && !(wb_act_s && (wb_addr == wa_addr));

    // Register array update; entry 0 is never written and stays zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wb_act_s) begin
                regs_r[wb_addr] <= wb_data;
            end
            if (wa_store_s) begin
                regs_r[wa_addr] <= wa_data;
            end
        end
    end

    kgp_rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .claim_en   (claim_act_s),
        .claim_addr (claim_addr),
        .wa_en      (wa_act_s),
        .wa_addr    (wa_addr),
        .wb_en      (wb_act_s),
        .wb_addr    (wb_addr),
        .busy       (busy_vec_s),
        .busy_any   (busy_any)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        localparam int A_LSB = port_lsb(k, ADDR_W);
        localparam int D_LSB = port_lsb(k, DATA_W);

        logic [ADDR_W-1:0] addr_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;
        logic              wa_hit_s;
        logic              wb_hit_s;

        assign addr_s = rd_addr[A_LSB +: ADDR_W];

        // Read mux: zero register, then forwarded write data (B over A), then storage.
        always_comb begin
            wa_hit_s = 1'b0;
            wb_hit_s = 1'b0;
            data_s   = {DATA_W{1'b0}};
            busy_s   = 1'b0;
            if (BYPASS != 32'sd0) begin
                wa_hit_s = wa_act_s && (wa_addr == addr_s);
                wb_hit_s = wb_act_s && (wb_addr == addr_s);
            end else begin
                wa_hit_s = 1'b0;
                wb_hit_s = 1'b0;
            end
            if (addr_s == ZERO_ADDR) begin
                data_s = {DATA_W{1'b0}};
            end else if (wb_hit_s) begin
                data_s = wb_data;
            end else if (wa_hit_s) begin
                data_s = wa_data;
            end else begin
                data_s = regs_r[addr_s];
            end
            // A result arriving this cycle is already forwarded, so it is not a hazard.
            if (wb_hit_s || wa_hit_s) begin
                busy_s = 1'b0;
            end else begin
                busy_s = busy_vec_s[addr_s];
            end
        end

        assign rd_data[D_LSB +: DATA_W] = data_s;
        assign rd_busy[k]               = busy_s;
    end

endmodule

// File: tb/tb_kgp_reg_file.sv
// Directed bench for kgp_reg_file: a 4-port bypassing instance and a 2-port
// non-bypassing instance share write/claim stimulus; expected values are
// queued as each step is driven and popped against the outputs mid-cycle.
module tb_kgp_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int K_DATA    = 0;
    localparam int K_BUSY    = 1;
    localparam int K_ANY     = 2;
    localparam int K_NB_DATA = 3;
    localparam int K_NB_BUSY = 4;
    localparam int K_NB_ANY  = 5;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];

    logic            clock;
    logic            reset;
    logic [4*AW-1:0] rd_addr;
    logic [4*DW-1:0] rd_data;
    logic [3:0]      rd_busy;
    logic            busy_any;
    logic [2*AW-1:0] rd_addr_nb;
    logic [2*DW-1:0] rd_data_nb;
    logic [1:0]      rd_busy_nb;
    logic            busy_any_nb;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [DW-1:0]   wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic            claim_en;
    logic [AW-1:0]   claim_addr;

    int checks = 0;
    int errors = 0;

    kgp_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .BYPASS(1)) dut (
        .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(busy_any)
    );

    kgp_reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .rd_addr(rd_addr_nb), .rd_data(rd_data_nb),
        .rd_busy(rd_busy_nb), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .claim_en(claim_en), .claim_addr(claim_addr), .busy_any(busy_any_nb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] observe(input int kind, input int port);
        case (kind)
            K_DATA:    return rd_data[port*DW +: DW];
            K_BUSY:    return {31'd0, rd_busy[port]};
            K_ANY:     return {31'd0, busy_any};
            K_NB_DATA: return rd_data_nb[port*DW +: DW];
            K_NB_BUSY: return {31'd0, rd_busy_nb[port]};
            K_NB_ANY:  return {31'd0, busy_any_nb};
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int kind, input int port, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.exp  = v;
        exp_q.push_back(e);
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_rd_nb(input int p, input logic [AW-1:0] a);
        rd_addr_nb[p*AW +: AW] = a;
    endtask

    task automatic check_pending();
        exp_t        e;
        logic [31:0] obs;
        #2;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind, e.port);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        claim_en = 1'b0; claim_addr = '0;
        rd_addr = '0; rd_addr_nb = '0;

        // Writes and claims presented while reset is high must be invisible.
        #50;
        wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'd99;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd88;
        claim_en = 1'b1; claim_addr = 5'd2;
        set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd31); set_rd(3, 5'd0);
        set_rd_nb(0, 5'd1); set_rd_nb(1, 5'd2);
        exp_push("in_rst_r1", K_DATA, 0, 32'd0);
        exp_push("in_rst_r2", K_DATA, 1, 32'd0);
        exp_push("in_rst_busy", K_BUSY, 1, 32'd0);
        exp_push("in_rst_any", K_ANY, 0, 32'd0);
        exp_push("in_rst_nb_r1", K_NB_DATA, 0, 32'd0);
        check_pending();
        #45;
        wa_en = 1'b0; wb_en = 1'b0; claim_en = 1'b0;
        #4;
        reset = 1'b0;

        exp_push("post_rst_r1", K_DATA, 0, 32'd0);
        exp_push("post_rst_r2", K_DATA, 1, 32'd0);
        exp_push("post_rst_r31", K_DATA, 2, 32'd0);
        exp_push("post_rst_busy0", K_BUSY, 0, 32'd0);
        exp_push("post_rst_busy1", K_BUSY, 1, 32'd0);
        exp_push("post_rst_any", K_ANY, 0, 32'd0);
        exp_push("post_rst_nb_any", K_NB_ANY, 0, 32'd0);
        check_pending();
        tick();

        // wa r1 = 16
        wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'd16;
        exp_push("bypass_wa_r1", K_DATA, 0, 32'd16);
        exp_push("nobyp_wa_r1", K_NB_DATA, 0, 32'd0);
        check_pending();
        tick();

        // wb r2 = -5
        wa_en = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hFFFF_FFFB;
        exp_push("r1_stored", K_DATA, 0, 32'd16);
        exp_push("nb_r1_stored", K_NB_DATA, 0, 32'd16);
        exp_push("bypass_wb_r2", K_DATA, 1, 32'hFFFF_FFFB);
        exp_push("nobyp_wb_r2", K_NB_DATA, 1, 32'd0);
        check_pending();
        tick();

        // write r0 = 7 is discarded
        wb_en = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'd7;
        set_rd(3, 5'd0); set_rd_nb(0, 5'd0);
        exp_push("r0_write_bypass", K_DATA, 3, 32'd0);
        exp_push("r2_stored", K_DATA, 1, 32'hFFFF_FFFB);
        exp_push("nb_r2_stored", K_NB_DATA, 1, 32'hFFFF_FFFB);
        exp_push("nb_r0_write", K_NB_DATA, 0, 32'd0);
        check_pending();
        tick();

        // same edge: wa r3 = 10, wb r3 = 20
        wa_en = 1'b1; wa_addr = 5'd3; wa_data = 32'd10;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd20;
        set_rd(2, 5'd3); set_rd_nb(0, 5'd3);
        exp_push("r0_stored", K_DATA, 3, 32'd0);
        exp_push("same_addr_bypass", K_DATA, 2, 32'd20);
        exp_push("same_addr_nobyp", K_NB_DATA, 0, 32'd0);
        check_pending();
        tick();

        // claim r4
        wa_en = 1'b0; wb_en = 1'b0;
        claim_en = 1'b1; claim_addr = 5'd4;
        set_rd(0, 5'd4); set_rd_nb(1, 5'd4);
        exp_push("same_addr_stored", K_DATA, 2, 32'd20);
        exp_push("nb_same_addr_stored", K_NB_DATA, 0, 32'd20);
        exp_push("claim_latency", K_BUSY, 0, 32'd0);
        exp_push("nb_claim_latency", K_NB_BUSY, 1, 32'd0);
        exp_push("busy_any_pre", K_ANY, 0, 32'd0);
        check_pending();
        tick();

        claim_en = 1'b0;
        exp_push("claim_busy", K_BUSY, 0, 32'd1);
        exp_push("claim_any", K_ANY, 0, 32'd1);
        exp_push("nb_claim_busy", K_NB_BUSY, 1, 32'd1);
        exp_push("nb_claim_any", K_NB_ANY, 0, 32'd1);
        check_pending();
        // wb r4 = 9 releases it
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'd9;
        exp_push("busy_mask_byp", K_BUSY, 0, 32'd0);
        exp_push("busy_nomask", K_NB_BUSY, 1, 32'd1);
        exp_push("any_nomask", K_ANY, 0, 32'd1);
        exp_push("bypass_r4", K_DATA, 0, 32'd9);
        check_pending();
        tick();

        wb_en = 1'b0;
        exp_push("r4_stored", K_DATA, 0, 32'd9);
        exp_push("busy_cleared", K_BUSY, 0, 32'd0);
        exp_push("any_cleared", K_ANY, 0, 32'd0);
        exp_push("nb_r4_stored", K_NB_DATA, 1, 32'd9);
        exp_push("nb_busy_cleared", K_NB_BUSY, 1, 32'd0);
        check_pending();
        // claim and write r5 in the same cycle
        claim_en = 1'b1; claim_addr = 5'd5;
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'd55;
        tick();

        // claim r0 is ignored
        wa_en = 1'b0;
        claim_en = 1'b1; claim_addr = 5'd0;
        set_rd(0, 5'd5); set_rd(3, 5'd0); set_rd_nb(1, 5'd5);
        exp_push("claim_write_data", K_DATA, 0, 32'd55);
        exp_push("claim_write_busy", K_BUSY, 0, 32'd1);
        exp_push("nb_claim_write_busy", K_NB_BUSY, 1, 32'd1);
        exp_push("claim_write_any", K_ANY, 0, 32'd1);
        check_pending();
        tick();

        // claim r6
        claim_en = 1'b1; claim_addr = 5'd6;
        exp_push("claim_r0_ignored", K_BUSY, 3, 32'd0);
        exp_push("r5_still_busy", K_BUSY, 0, 32'd1);
        check_pending();
        tick();

        // wa r6 = 66 releases it
        claim_en = 1'b0;
        wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'd66;
        set_rd(1, 5'd6); set_rd_nb(0, 5'd6);
        exp_push("wa_busy_mask", K_BUSY, 1, 32'd0);
        exp_push("wa_busy_nomask", K_NB_BUSY, 0, 32'd1);
        exp_push("bypass_r6", K_DATA, 1, 32'd66);
        check_pending();
        tick();

        wa_en = 1'b0;
        exp_push("wa_busy_cleared", K_BUSY, 1, 32'd0);
        exp_push("nb_wa_busy_cleared", K_NB_BUSY, 0, 32'd0);
        exp_push("nb_r6_stored", K_NB_DATA, 0, 32'd66);
        check_pending();
        // different addresses on both ports are both stored
        wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'd1;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd2;
        tick();
        wa_addr = 5'd3; wa_data = 32'd3;
        wb_addr = 5'd31; wb_data = 32'd31;
        tick();

        wa_en = 1'b0; wb_en = 1'b0;
        set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd31);
        set_rd_nb(0, 5'd3); set_rd_nb(1, 5'd31);
        exp_push("rd4_p0_r1", K_DATA, 0, 32'd1);
        exp_push("rd4_p1_r2", K_DATA, 1, 32'd2);
        exp_push("rd4_p2_r3", K_DATA, 2, 32'd3);
        exp_push("rd4_p3_r31", K_DATA, 3, 32'd31);
        exp_push("nb_p0_r3", K_NB_DATA, 0, 32'd3);
        exp_push("nb_p1_r31", K_NB_DATA, 1, 32'd31);
        exp_push("any_r5_busy", K_ANY, 0, 32'd1);
        check_pending();

        // asynchronous reset in the middle of a cycle
        set_rd(0, 5'd4); set_rd(1, 5'd5); set_rd(2, 5'd1); set_rd(3, 5'd2);
        set_rd_nb(0, 5'd3); set_rd_nb(1, 5'd5);
        exp_push("pre_rst_r5", K_DATA, 1, 32'd55);
        exp_push("pre_rst_busy_r5", K_BUSY, 1, 32'd1);
        check_pending();
        reset = 1'b1;
        exp_push("async_rst_r4", K_DATA, 0, 32'd0);
        exp_push("async_rst_r5", K_DATA, 1, 32'd0);
        exp_push("async_rst_r1", K_DATA, 2, 32'd0);
        exp_push("async_rst_r2", K_DATA, 3, 32'd0);
        exp_push("async_rst_busy_r5", K_BUSY, 1, 32'd0);
        exp_push("async_rst_any", K_ANY, 0, 32'd0);
        exp_push("async_rst_nb_r3", K_NB_DATA, 0, 32'd0);
        exp_push("async_rst_nb_busy_r5", K_NB_BUSY, 1, 32'd0);
        exp_push("async_rst_nb_any", K_NB_ANY, 0, 32'd0);
        check_pending();
        wa_en = 1'b1; wa_addr = 5'd1; wa_data = 32'd77;
        claim_en = 1'b1; claim_addr = 5'd7;
        tick();

        reset = 1'b0;
        wa_en = 1'b0; claim_en = 1'b0;
        set_rd(3, 5'd7);
        exp_push("rst_cycle_write", K_DATA, 2, 32'd0);
        exp_push("rst_cycle_claim", K_BUSY, 3, 32'd0);
        exp_push("rst_cycle_any", K_ANY, 0, 32'd0);
        check_pending();
        tick();
        exp_push("after_rst_r1", K_DATA, 2, 32'd0);
        exp_push("after_rst_busy_r7", K_BUSY, 3, 32'd0);
        check_pending();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
